// File: rtl/crc32_stream_pkg.sv
// Shared CRC-32 constants, FSM state type and bit-serial helpers
// for the streaming CRC engine.
package crc_pkg;

  localparam logic [31:0] ETH_POLY    = 32'h04C11DB7;
  localparam logic [31:0] ETH_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] ETH_XOR_OUT = 32'hFFFFFFFF;
  localparam logic [31:0] ETH_RESIDUE = 32'hC704DD7B;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } crc_state_e;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // Register is kept in normal (MSB-feedback) form while data enters bit 0 first.
  function automatic logic [31:0] crc32_byte_step(input logic [31:0] poly,
                                                  input logic [31:0] crc,
                                                  input logic [7:0]  data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0} ^ (fb ? poly : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_stream_if.sv
// Beat-level input bundle of the CRC engine: valid/sop/eop qualified data
// with a byte-keep mask for the last beat.
interface crc32_stream_if #(
  parameter int DATA_W = 8
);
  logic                  in_valid;
  logic                  in_sop;
  logic                  in_eop;
  logic [DATA_W-1:0]     in_data;
  logic [DATA_W/8-1:0]   in_keep;

  modport master (
    output in_valid, in_sop, in_eop, in_data, in_keep
  );

  modport slave (
    input in_valid, in_sop, in_eop, in_data, in_keep
  );
endinterface

// File: rtl/crc32_stream_lane.sv
// One byte of the per-beat CRC chain; a disabled lane passes the CRC through.
module crc_byte_lane
  import crc_pkg::*;
#(
  parameter logic [31:0] POLY = ETH_POLY
) (
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  input  logic        en_i,
  output logic [31:0] crc_o
);

  assign crc_o = en_i ? crc32_byte_step(POLY, crc_i, data_i) : crc_i;

endmodule

// File: rtl/crc32_stream.sv
// Streaming CRC-32 engine: sop/eop framing, keep-masked last beat,
// finalised FCS and residue check one cycle after eop.
module crc32_stream
  import crc_pkg::*;
#(
  parameter int          DATA_W      = 8,
  parameter logic [31:0] POLY        = ETH_POLY,
  parameter logic [31:0] INIT        = ETH_INIT,
  parameter logic [31:0] XOR_OUT     = ETH_XOR_OUT,
  parameter bit          REFLECT_OUT = 1'b1,
  parameter logic [31:0] RESIDUE     = ETH_RESIDUE
) (
  input  logic        clk,
  input  logic        rst_n,
  crc32_stream_if.slave s_if,
  output logic [31:0] crc_raw,
  output logic [31:0] fcs_out,
  output logic        fcs_valid,
  output logic        chk_good,
  output logic        chk_bad,
  output logic        busy,
  output logic [15:0] byte_cnt,
  output logic        frame_err
);

  localparam int NB = DATA_W / 8;

  crc_state_e  state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] fcs_q, fcs_d;
  logic [15:0] cnt_q, cnt_d;
  logic        fcs_valid_q, fcs_valid_d;
  logic        good_q, good_d;
  logic        bad_q, bad_d;
  logic        err_q, err_d;
  logic        busy_q;

  logic          accept_s, seed_s, close_s, err_s;
  logic [NB-1:0] lane_en_s;
  logic [3:0]    lanes_s;
  logic [3:0]    add_s;
  logic          keep_run_s;
  logic [15:0]   cnt_base_s;
  logic [16:0]   cnt_sum_s;
  logic [31:0]   chain_s [NB+1];

  // Keep mask reduced to its leading ones; this also absorbs non-contiguous masks.
  always_comb begin
    keep_run_s = 1'b1;
    lanes_s    = 4'd0;
    lane_en_s  = '0;
    for (int k = 0; k < NB; k++) begin
      keep_run_s   = keep_run_s & s_if.in_keep[k];
      lane_en_s[k] = s_if.in_eop ? keep_run_s : 1'b1;
      lanes_s      = lanes_s + {3'b000, keep_run_s};
    end
  end

  assign chain_s[0] = seed_s ? INIT : crc_q;

  for (genvar k = 0; k < NB; k++) begin : g_lane
    crc_byte_lane #(.POLY(POLY)) u_lane (
      .crc_i  (chain_s[k]),
      .data_i (s_if.in_data[8*k +: 8]),
      .en_i   (lane_en_s[k]),
      .crc_o  (chain_s[k+1])
    );
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (s_if.in_valid && s_if.in_sop && !s_if.in_eop) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (s_if.in_valid && s_if.in_eop) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output decode: beat acceptance, seeding, frame close and protocol errors
  always_comb begin
    accept_s = 1'b0;
    seed_s   = 1'b0;
    err_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        accept_s = s_if.in_valid && s_if.in_sop;
        seed_s   = s_if.in_valid && s_if.in_sop;
        err_s    = s_if.in_valid && !s_if.in_sop;
      end
      ST_RUN: begin
        accept_s = s_if.in_valid;
        seed_s   = s_if.in_valid && s_if.in_sop;
        err_s    = s_if.in_valid && s_if.in_sop;
      end
      default: begin
        accept_s = 1'b0;
        seed_s   = 1'b0;
        err_s    = 1'b0;
      end
    endcase
    close_s = accept_s && s_if.in_eop;
  end

  // Datapath next-state: CRC register, saturating byte count, finalisation
  always_comb begin
    add_s      = s_if.in_eop ? lanes_s : 4'(NB);
    cnt_base_s = seed_s ? 16'h0000 : cnt_q;
    cnt_sum_s  = {1'b0, cnt_base_s} + {13'b0, add_s};
    if (accept_s) begin
      crc_d = chain_s[NB];
      cnt_d = cnt_sum_s[16] ? 16'hFFFF : cnt_sum_s[15:0];
    end else begin
      crc_d = crc_q;
      cnt_d = cnt_q;
    end
    fcs_valid_d = close_s;
    good_d      = close_s && (crc_d == RESIDUE);
    bad_d       = close_s && (crc_d != RESIDUE);
    err_d       = err_s || (close_s && (lanes_s == 4'd0));
    if (close_s) begin
      fcs_d = (REFLECT_OUT ? bitrev32(crc_d) : crc_d) ^ XOR_OUT;
    end else begin
      fcs_d = fcs_q;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q       <= INIT;
      fcs_q       <= 32'h0;
      cnt_q       <= 16'h0;
      fcs_valid_q <= 1'b0;
      good_q      <= 1'b0;
      bad_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      crc_q       <= crc_d;
      fcs_q       <= fcs_d;
      cnt_q       <= cnt_d;
      fcs_valid_q <= fcs_valid_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      err_q       <= err_d;
      busy_q      <= (state_d == ST_RUN);
    end
  end

  assign crc_raw   = crc_q;
  assign fcs_out   = fcs_q;
  assign fcs_valid = fcs_valid_q;
  assign chk_good  = good_q;
  assign chk_bad   = bad_q;
  assign busy      = busy_q;
  assign byte_cnt  = cnt_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_crc32_stream.sv
// Scoreboard bench for crc32_stream at DATA_W=8 and DATA_W=32 using
// hand-computed CRC-32 vectors.
module tb_crc32_stream;

  typedef struct {
    logic [31:0] fcs;
    logic        chk_fcs;
    logic        good;
    logic [15:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t q8[$];
  exp_t q32[$];
  exp_t e8;
  exp_t e32;
  logic [7:0] msg [9];

  crc32_stream_if #(.DATA_W(8))  if8 ();
  crc32_stream_if #(.DATA_W(32)) if32 ();

  logic [31:0] crc_raw8, fcs_out8, crc_raw32, fcs_out32;
  logic [15:0] byte_cnt8, byte_cnt32;
  logic fcs_valid8, chk_good8, chk_bad8, busy8, frame_err8;
  logic fcs_valid32, chk_good32, chk_bad32, busy32, frame_err32;

  crc32_stream #(.DATA_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .s_if(if8.slave),
    .crc_raw(crc_raw8), .fcs_out(fcs_out8), .fcs_valid(fcs_valid8),
    .chk_good(chk_good8), .chk_bad(chk_bad8), .busy(busy8),
    .byte_cnt(byte_cnt8), .frame_err(frame_err8)
  );

  crc32_stream #(.DATA_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .s_if(if32.slave),
    .crc_raw(crc_raw32), .fcs_out(fcs_out32), .fcs_valid(fcs_valid32),
    .chk_good(chk_good32), .chk_bad(chk_bad32), .busy(busy32),
    .byte_cnt(byte_cnt32), .frame_err(frame_err32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push8(input logic [31:0] f, input logic cf, input logic g, input logic [15:0] c);
    exp_t e;
    e.fcs = f; e.chk_fcs = cf; e.good = g; e.cnt = c;
    q8.push_back(e);
  endtask

  task automatic push32(input logic [31:0] f, input logic cf, input logic g, input logic [15:0] c);
    exp_t e;
    e.fcs = f; e.chk_fcs = cf; e.good = g; e.cnt = c;
    q32.push_back(e);
  endtask

  task automatic b8(input logic sop, input logic eop, input logic [7:0] d);
    @(negedge clk);
    if8.in_valid = 1'b1; if8.in_sop = sop; if8.in_eop = eop;
    if8.in_data = d; if8.in_keep = 1'b1;
  endtask

  task automatic idle8();
    @(negedge clk);
    if8.in_valid = 1'b0; if8.in_sop = 1'b0; if8.in_eop = 1'b0;
  endtask

  task automatic b32(input logic sop, input logic eop, input logic [31:0] d, input logic [3:0] k);
    @(negedge clk);
    if32.in_valid = 1'b1; if32.in_sop = sop; if32.in_eop = eop;
    if32.in_data = d; if32.in_keep = k;
  endtask

  task automatic idle32();
    @(negedge clk);
    if32.in_valid = 1'b0; if32.in_sop = 1'b0; if32.in_eop = 1'b0;
  endtask

  // Monitors: every fcs_valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (fcs_valid8) begin
      if (q8.size() == 0) begin
        chk("m8_unexpected_fcs_valid", 32'd1, 32'd0);
      end else begin
        e8 = q8.pop_front();
        if (e8.chk_fcs) chk("m8_fcs_out", fcs_out8, e8.fcs);
        chk("m8_chk_good", {31'd0, chk_good8}, {31'd0, e8.good});
        chk("m8_chk_bad", {31'd0, chk_bad8}, {31'd0, ~e8.good});
        chk("m8_byte_cnt", {16'd0, byte_cnt8}, {16'd0, e8.cnt});
      end
    end
  end

  always @(negedge clk) begin
    if (fcs_valid32) begin
      if (q32.size() == 0) begin
        chk("m32_unexpected_fcs_valid", 32'd1, 32'd0);
      end else begin
        e32 = q32.pop_front();
        if (e32.chk_fcs) chk("m32_fcs_out", fcs_out32, e32.fcs);
        chk("m32_chk_good", {31'd0, chk_good32}, {31'd0, e32.good});
        chk("m32_chk_bad", {31'd0, chk_bad32}, {31'd0, ~e32.good});
        chk("m32_byte_cnt", {16'd0, byte_cnt32}, {16'd0, e32.cnt});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    rst_n = 1'b0;
    if8.in_valid = 1'b0; if8.in_sop = 1'b0; if8.in_eop = 1'b0;
    if8.in_data = 8'h00; if8.in_keep = 1'b0;
    if32.in_valid = 1'b0; if32.in_sop = 1'b0; if32.in_eop = 1'b0;
    if32.in_data = 32'h0; if32.in_keep = 4'h0;
    #12;
    chk("rst_crc_raw8", crc_raw8, 32'hFFFFFFFF);
    chk("rst_fcs_out8", fcs_out8, 32'h0);
    chk("rst_flags8", {27'd0, fcs_valid8, chk_good8, chk_bad8, busy8, frame_err8}, 32'd0);
    chk("rst_byte_cnt8", {16'd0, byte_cnt8}, 32'd0);
    chk("rst_crc_raw32", crc_raw32, 32'hFFFFFFFF);
    chk("rst_flags32", {27'd0, fcs_valid32, chk_good32, chk_bad32, busy32, frame_err32}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // "123456789" byte by byte
    push8(32'hCBF43926, 1'b1, 1'b0, 16'd9);
    b8(1'b1, 1'b0, msg[0]);
    for (int i = 1; i < 9; i++) begin
      b8(1'b0, i == 8, msg[i]);
      if (i == 1) chk("busy_run8", {31'd0, busy8}, 32'd1);
    end
    idle8();
    chk("busy_fall8", {31'd0, busy8}, 32'd0);
    chk("crc_raw_check8", crc_raw8, 32'h9B63D02C);

    // back-to-back single-byte frames
    push8(32'hD202EF8D, 1'b1, 1'b0, 16'd1);
    push8(32'hFF000000, 1'b1, 1'b0, 16'd1);
    b8(1'b1, 1'b1, 8'h00);
    b8(1'b1, 1'b1, 8'hFF);
    idle8();
    idle8();
    chk("b2b_crc_raw8", crc_raw8, 32'hFFFFFF00);

    // beat without sop in IDLE is dropped
    b8(1'b0, 1'b0, 8'hA5);
    idle8();
    chk("nosop_frame_err", {31'd0, frame_err8}, 32'd1);
    chk("nosop_crc_raw", crc_raw8, 32'hFFFFFF00);
    chk("nosop_byte_cnt", {16'd0, byte_cnt8}, 32'd1);
    idle8();
    chk("frame_err_pulse", {31'd0, frame_err8}, 32'd0);

    // sop in RUN restarts; only the restarted frame reports
    b8(1'b1, 1'b0, msg[0]);
    b8(1'b0, 1'b0, msg[1]);
    push8(32'hCBF43926, 1'b1, 1'b0, 16'd9);
    b8(1'b1, 1'b0, msg[0]);
    for (int i = 1; i < 9; i++) begin
      b8(1'b0, i == 8, msg[i]);
      if (i == 1) begin
        chk("restart_frame_err", {31'd0, frame_err8}, 32'd1);
        chk("restart_byte_cnt", {16'd0, byte_cnt8}, 32'd1);
      end
    end
    idle8();
    idle8();

    // reset mid-frame
    b8(1'b1, 1'b0, msg[0]);
    b8(1'b0, 1'b0, msg[1]);
    b8(1'b0, 1'b0, msg[2]);
    #1;
    rst_n = 1'b0;
    if8.in_valid = 1'b0;
    #1;
    chk("midrst_crc_raw", crc_raw8, 32'hFFFFFFFF);
    chk("midrst_fcs_out", fcs_out8, 32'h0);
    chk("midrst_byte_cnt", {16'd0, byte_cnt8}, 32'd0);
    chk("midrst_flags", {27'd0, fcs_valid8, chk_good8, chk_bad8, busy8, frame_err8}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push8(32'hCBF43926, 1'b1, 1'b0, 16'd9);
    for (int i = 0; i < 9; i++) begin
      b8(i == 0, i == 8, msg[i]);
    end
    idle8();
    idle8();

    // 32-bit: "123456789" in three beats, last keep=0001
    push32(32'hCBF43926, 1'b1, 1'b0, 16'd9);
    b32(1'b1, 1'b0, 32'h34333231, 4'hF);
    b32(1'b0, 1'b0, 32'h38373635, 4'hF);
    b32(1'b0, 1'b1, 32'h00000039, 4'h1);
    idle32();

    // 32-bit: data plus FCS (26 39 F4 CB) hits the residue
    push32(32'h2144DF1C, 1'b1, 1'b1, 16'd13);
    b32(1'b1, 1'b0, 32'h34333231, 4'hF);
    b32(1'b0, 1'b0, 32'h38373635, 4'hF);
    b32(1'b0, 1'b0, 32'hF4392639, 4'hF);
    b32(1'b0, 1'b1, 32'h000000CB, 4'h1);
    idle32();
    chk("residue_crc_raw32", crc_raw32, 32'hC704DD7B);

    // same frame with one flipped bit
    push32(32'h0, 1'b0, 1'b0, 16'd13);
    b32(1'b1, 1'b0, 32'h34333230, 4'hF);
    b32(1'b0, 1'b0, 32'h38373635, 4'hF);
    b32(1'b0, 1'b0, 32'hF4392639, 4'hF);
    b32(1'b0, 1'b1, 32'h000000CB, 4'h1);
    idle32();
    idle32();
    idle32();

    chk("q8_drained", q8.size(), 32'd0);
    chk("q32_drained", q32.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
